// File: rtl/decode_pkg.sv
// decode_pkg
//   Shared definitions for the decode-side instruction queue: field widths
//   of the decode mux outputs, the flat bit layout of one queue entry, the
//   functional-unit identifiers and the register access pattern codes.
//   No ports (package).
package decode_pkg;

  // Field widths, identical to the decode mux outputs.
  localparam int unsigned opcodeSize              = 12;
  localparam int unsigned addressWidth            = 64;
  localparam int unsigned funcUnitCodeSize        = 3;
  localparam int unsigned instructionCounterWidth = 64;
  localparam int unsigned instMinIdWidth          = 7;
  localparam int unsigned PidSize                 = 20;
  localparam int unsigned TidSize                 = 16;
  localparam int unsigned regAccessPatternSize    = 2;
  localparam int unsigned bodyWidth               = 84;

  // Entry layout, LSB first: body, opNIsReg (op4 lowest), opNrw (op4 lowest),
  // tid, pid, is64Bit, minID, majID, funcUnitType, address, opcode.
  localparam int unsigned bodyOffset         = 0;
  localparam int unsigned op4IsRegOffset     = bodyOffset + bodyWidth;
  localparam int unsigned op3IsRegOffset     = op4IsRegOffset + 1;
  localparam int unsigned op2IsRegOffset     = op3IsRegOffset + 1;
  localparam int unsigned op1IsRegOffset     = op2IsRegOffset + 1;
  localparam int unsigned op4rwOffset        = op1IsRegOffset + 1;
  localparam int unsigned op3rwOffset        = op4rwOffset + regAccessPatternSize;
  localparam int unsigned op2rwOffset        = op3rwOffset + regAccessPatternSize;
  localparam int unsigned op1rwOffset        = op2rwOffset + regAccessPatternSize;
  localparam int unsigned tidOffset          = op1rwOffset + regAccessPatternSize;
  localparam int unsigned pidOffset          = tidOffset + TidSize;
  localparam int unsigned is64BitOffset      = pidOffset + PidSize;
  localparam int unsigned minIDOffset        = is64BitOffset + 1;
  localparam int unsigned majIDOffset        = minIDOffset + instMinIdWidth;
  localparam int unsigned funcUnitTypeOffset = majIDOffset + instructionCounterWidth;
  localparam int unsigned addressOffset      = funcUnitTypeOffset + funcUnitCodeSize;
  localparam int unsigned opcodeOffset       = addressOffset + addressWidth;

  // Total entry width: 283 bits.
  localparam int unsigned entryWidth = opcodeOffset + opcodeSize;

  typedef logic [entryWidth-1:0] entry_t;

  // Functional unit identifiers (codes 5 and 7 are unassigned).
  typedef enum logic [funcUnitCodeSize-1:0] {
    fuFX     = 3'd0,
    fuFP     = 3'd1,
    fuVX     = 3'd2,
    fuCR     = 3'd3,
    fuLS     = 3'd4,
    fuBranch = 3'd6
  } funcUnit_e;

  // Register access pattern codes.
  localparam logic [regAccessPatternSize-1:0] regRead  = 2'b10;
  localparam logic [regAccessPatternSize-1:0] regWrite = 2'b01;

endpackage

// File: rtl/decode_inst_queue_if.sv
// decode_inst_queue_if
//   Bundles the push side (decode mux -> queue), the status flags and the
//   pop side (queue -> issue/rename) of the decoded-instruction queue.
//   Modports:
//     slave  - the queue itself (decode_inst_queue)
//     master - the surrounding decode front end and issue consumer
//   Optional: DECODE_QUEUE_STATS_EN adds pushCount_o, popCount_o, dropCount_o.
interface decode_inst_queue_if;
  import decode_pkg::*;

  // Push side
  logic                                 flush_i;
  logic                                 enable_i;
  logic [opcodeSize-1:0]                opcode_i;
  logic [addressWidth-1:0]              address_i;
  logic [funcUnitCodeSize-1:0]          funcUnitType_i;
  logic [instructionCounterWidth-1:0]   majID_i;
  logic [instMinIdWidth-1:0]            minID_i;
  logic                                 is64Bit_i;
  logic [PidSize-1:0]                   pid_i;
  logic [TidSize-1:0]                   tid_i;
  logic [regAccessPatternSize-1:0]      op1rw_i;
  logic [regAccessPatternSize-1:0]      op2rw_i;
  logic [regAccessPatternSize-1:0]      op3rw_i;
  logic [regAccessPatternSize-1:0]      op4rw_i;
  logic                                 op1IsReg_i;
  logic                                 op2IsReg_i;
  logic                                 op3IsReg_i;
  logic                                 op4IsReg_i;
  logic [bodyWidth-1:0]                 body_i;

  // Status
  logic                                 stall_o;
  logic                                 overflow_o;

  // Pop side
  logic                                 valid_o;
  logic                                 ready_i;
  logic [opcodeSize-1:0]                opcode_o;
  logic [addressWidth-1:0]              address_o;
  logic [funcUnitCodeSize-1:0]          funcUnitType_o;
  logic [instructionCounterWidth-1:0]   majID_o;
  logic [instMinIdWidth-1:0]            minID_o;
  logic                                 is64Bit_o;
  logic [PidSize-1:0]                   pid_o;
  logic [TidSize-1:0]                   tid_o;
  logic [regAccessPatternSize-1:0]      op1rw_o;
  logic [regAccessPatternSize-1:0]      op2rw_o;
  logic [regAccessPatternSize-1:0]      op3rw_o;
  logic [regAccessPatternSize-1:0]      op4rw_o;
  logic                                 op1IsReg_o;
  logic                                 op2IsReg_o;
  logic                                 op3IsReg_o;
  logic                                 op4IsReg_o;
  logic [bodyWidth-1:0]                 body_o;

`ifdef DECODE_QUEUE_STATS_EN
  logic [63:0]                          pushCount_o;
  logic [63:0]                          popCount_o;
  logic [31:0]                          dropCount_o;
`endif

  modport slave (
    input  flush_i, enable_i,
    input  opcode_i, address_i, funcUnitType_i, majID_i, minID_i, is64Bit_i,
    input  pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i, op4rw_i,
    input  op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, body_i,
    output stall_o, overflow_o,
    output valid_o,
    input  ready_i,
    output opcode_o, address_o, funcUnitType_o, majID_o, minID_o, is64Bit_o,
    output pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o,
    output op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o
`ifdef DECODE_QUEUE_STATS_EN
    , output pushCount_o, popCount_o, dropCount_o
`endif
  );

  modport master (
    output flush_i, enable_i,
    output opcode_i, address_i, funcUnitType_i, majID_i, minID_i, is64Bit_i,
    output pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i, op4rw_i,
    output op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, body_i,
    input  stall_o, overflow_o,
    input  valid_o,
    output ready_i,
    input  opcode_o, address_o, funcUnitType_o, majID_o, minID_o, is64Bit_o,
    input  pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o,
    input  op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o
`ifdef DECODE_QUEUE_STATS_EN
    , input pushCount_o, popCount_o, dropCount_o
`endif
  );

endinterface

// File: rtl/decode_queue_ram.sv
// decode_queue_ram
//   depth x entryWidth register array backing the decoded-instruction queue.
//   One synchronous write port, one combinational read port. No reset: the
//   queue masks stale contents through its own valid tracking.
//   Ports:
//     clock_i   in   clock
//     wrEn_i    in   write strobe
//     wrAddr_i  in   write slot
//     wrData_i  in   entry to store
//     rdAddr_i  in   read slot
//     rdData_o  out  entry at rdAddr_i (combinational)
module decode_queue_ram
  import decode_pkg::*;
#(
  parameter int unsigned depth = 8,
  localparam int unsigned addrWidth = $clog2(depth)
) (
  input  logic                 clock_i,
  input  logic                 wrEn_i,
  input  logic [addrWidth-1:0] wrAddr_i,
  input  entry_t               wrData_i,
  input  logic [addrWidth-1:0] rdAddr_i,
  output entry_t               rdData_o
);

  entry_t mem [depth];

  always_ff @(posedge clock_i) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = mem[rdAddr_i];

endmodule

// File: rtl/decode_inst_queue.sv
// decode_inst_queue
//   In-order FIFO of merged A/B/D-format decoded instructions between the
//   decode mux and issue/rename. One push and one pop per cycle; the head
//   entry is presented with valid/ready. stall_o is raised early (stallSlack
//   free entries left) because the mux cannot be back-pressured directly.
//   Ports:
//     clock_i  in  clock, rising edge
//     reset_i  in  synchronous active-high reset
//     dq       decode_inst_queue_if.slave: push fields/enable/flush, ready,
//              stall/overflow flags, head valid and head fields
//   Optional: DECODE_QUEUE_STATS_EN adds push/pop/drop counters that are
//   cleared only by reset and wrap on overflow.
module decode_inst_queue
  import decode_pkg::*;
#(
  parameter int unsigned depth      = 8,
  parameter int unsigned stallSlack = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  decode_inst_queue_if.slave    dq
);

  localparam int unsigned ptrWidth = $clog2(depth);
  localparam logic [ptrWidth:0] fullLevel  = (ptrWidth+1)'(depth);
  localparam logic [ptrWidth:0] stallLevel = (ptrWidth+1)'(depth - stallSlack);

  logic [ptrWidth-1:0] head;
  logic [ptrWidth-1:0] tail;
  logic [ptrWidth:0]   count;
  logic                overflow;

  logic   valid;
  logic   push;
  logic   pop;
  logic   drop;
  logic   wrEn;
  entry_t wrData;
  entry_t rdData;
  entry_t headData;

  // A pop in the same cycle frees the slot, so a full queue still accepts.
  always_comb begin
    valid = (count != '0);
    pop   = valid && dq.ready_i;
    push  = dq.enable_i && ((count < fullLevel) || pop);
    drop  = dq.enable_i && !push;
    wrEn  = push && !dq.flush_i && !reset_i;
  end

  always_comb begin
    wrData = '0;
    wrData[opcodeOffset       +: opcodeSize]              = dq.opcode_i;
    wrData[addressOffset      +: addressWidth]            = dq.address_i;
    wrData[funcUnitTypeOffset +: funcUnitCodeSize]        = dq.funcUnitType_i;
    wrData[majIDOffset        +: instructionCounterWidth] = dq.majID_i;
    wrData[minIDOffset        +: instMinIdWidth]          = dq.minID_i;
    wrData[is64BitOffset]                                 = dq.is64Bit_i;
    wrData[pidOffset          +: PidSize]                 = dq.pid_i;
    wrData[tidOffset          +: TidSize]                 = dq.tid_i;
    wrData[op1rwOffset        +: regAccessPatternSize]    = dq.op1rw_i;
    wrData[op2rwOffset        +: regAccessPatternSize]    = dq.op2rw_i;
    wrData[op3rwOffset        +: regAccessPatternSize]    = dq.op3rw_i;
    wrData[op4rwOffset        +: regAccessPatternSize]    = dq.op4rw_i;
    wrData[op1IsRegOffset]                                = dq.op1IsReg_i;
    wrData[op2IsRegOffset]                                = dq.op2IsReg_i;
    wrData[op3IsRegOffset]                                = dq.op3IsReg_i;
    wrData[op4IsRegOffset]                                = dq.op4IsReg_i;
    wrData[bodyOffset         +: bodyWidth]               = dq.body_i;
  end

  decode_queue_ram #(.depth(depth)) ram (
    .clock_i  (clock_i),
    .wrEn_i   (wrEn),
    .wrAddr_i (tail),
    .wrData_i (wrData),
    .rdAddr_i (head),
    .rdData_o (rdData)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (dq.flush_i) begin
      // Flush discards the contents but keeps the sticky overflow flag.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Head fields read as zero whenever the queue is empty.
  assign headData = valid ? rdData : '0;

  assign dq.valid_o        = valid;
  assign dq.stall_o        = (count >= stallLevel);
  assign dq.overflow_o     = overflow;

  assign dq.opcode_o       = headData[opcodeOffset       +: opcodeSize];
  assign dq.address_o      = headData[addressOffset      +: addressWidth];
  assign dq.funcUnitType_o = headData[funcUnitTypeOffset +: funcUnitCodeSize];
  assign dq.majID_o        = headData[majIDOffset        +: instructionCounterWidth];
  assign dq.minID_o        = headData[minIDOffset        +: instMinIdWidth];
  assign dq.is64Bit_o      = headData[is64BitOffset];
  assign dq.pid_o          = headData[pidOffset          +: PidSize];
  assign dq.tid_o          = headData[tidOffset          +: TidSize];
  assign dq.op1rw_o        = headData[op1rwOffset        +: regAccessPatternSize];
  assign dq.op2rw_o        = headData[op2rwOffset        +: regAccessPatternSize];
  assign dq.op3rw_o        = headData[op3rwOffset        +: regAccessPatternSize];
  assign dq.op4rw_o        = headData[op4rwOffset        +: regAccessPatternSize];
  assign dq.op1IsReg_o     = headData[op1IsRegOffset];
  assign dq.op2IsReg_o     = headData[op2IsRegOffset];
  assign dq.op3IsReg_o     = headData[op3IsRegOffset];
  assign dq.op4IsReg_o     = headData[op4IsRegOffset];
  assign dq.body_o         = headData[bodyOffset         +: bodyWidth];

`ifdef DECODE_QUEUE_STATS_EN
  logic [63:0] pushCount;
  logic [63:0] popCount;
  logic [31:0] dropCount;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pushCount <= '0;
      popCount  <= '0;
      dropCount <= '0;
    end else if (!dq.flush_i) begin
      if (push) begin
        pushCount <= pushCount + 1'b1;
      end
      if (pop) begin
        popCount <= popCount + 1'b1;
      end
      if (drop) begin
        dropCount <= dropCount + 1'b1;
      end
    end
  end

  assign dq.pushCount_o = pushCount;
  assign dq.popCount_o  = popCount;
  assign dq.dropCount_o = dropCount;
`endif

endmodule

// File: tb/tb_decode_inst_queue.sv
module tb_decode_inst_queue;
  import decode_pkg::*;

  localparam int unsigned depth      = 8;
  localparam int unsigned stallSlack = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_inst_queue_if dif();

  decode_inst_queue #(.depth(depth), .stallSlack(stallSlack)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .dq      (dif)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of entries plus the sticky drop flag.
  entry_t mq[$];
  logic   mOvf = 1'b0;

  typedef struct {
    logic        rst;
    logic        en;
    logic        rdy;
    logic [63:0] maj;
    logic        expValid;
    logic        expStall;
    logic        expOvf;
    logic [63:0] expMaj;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [entryWidth-1:0] act,
                       input logic [entryWidth-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic entry_t actualHead();
    entry_t e;
    e = '0;
    e[opcodeOffset       +: opcodeSize]              = dif.opcode_o;
    e[addressOffset      +: addressWidth]            = dif.address_o;
    e[funcUnitTypeOffset +: funcUnitCodeSize]        = dif.funcUnitType_o;
    e[majIDOffset        +: instructionCounterWidth] = dif.majID_o;
    e[minIDOffset        +: instMinIdWidth]          = dif.minID_o;
    e[is64BitOffset]                                 = dif.is64Bit_o;
    e[pidOffset          +: PidSize]                 = dif.pid_o;
    e[tidOffset          +: TidSize]                 = dif.tid_o;
    e[op1rwOffset        +: regAccessPatternSize]    = dif.op1rw_o;
    e[op2rwOffset        +: regAccessPatternSize]    = dif.op2rw_o;
    e[op3rwOffset        +: regAccessPatternSize]    = dif.op3rw_o;
    e[op4rwOffset        +: regAccessPatternSize]    = dif.op4rw_o;
    e[op1IsRegOffset]                                = dif.op1IsReg_o;
    e[op2IsRegOffset]                                = dif.op2IsReg_o;
    e[op3IsRegOffset]                                = dif.op3IsReg_o;
    e[op4IsRegOffset]                                = dif.op4IsReg_o;
    e[bodyOffset         +: bodyWidth]               = dif.body_o;
    return e;
  endfunction

  task automatic driveEntry(input entry_t e);
    dif.opcode_i       = e[opcodeOffset       +: opcodeSize];
    dif.address_i      = e[addressOffset      +: addressWidth];
    dif.funcUnitType_i = e[funcUnitTypeOffset +: funcUnitCodeSize];
    dif.majID_i        = e[majIDOffset        +: instructionCounterWidth];
    dif.minID_i        = e[minIDOffset        +: instMinIdWidth];
    dif.is64Bit_i      = e[is64BitOffset];
    dif.pid_i          = e[pidOffset          +: PidSize];
    dif.tid_i          = e[tidOffset          +: TidSize];
    dif.op1rw_i        = e[op1rwOffset        +: regAccessPatternSize];
    dif.op2rw_i        = e[op2rwOffset        +: regAccessPatternSize];
    dif.op3rw_i        = e[op3rwOffset        +: regAccessPatternSize];
    dif.op4rw_i        = e[op4rwOffset        +: regAccessPatternSize];
    dif.op1IsReg_i     = e[op1IsRegOffset];
    dif.op2IsReg_i     = e[op2IsRegOffset];
    dif.op3IsReg_i     = e[op3IsRegOffset];
    dif.op4IsReg_i     = e[op4IsRegOffset];
    dif.body_i         = e[bodyOffset         +: bodyWidth];
  endtask

  function automatic entry_t randEntry();
    logic [287:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return w[entryWidth-1:0];
  endfunction

  function automatic entry_t withMaj(input entry_t base, input logic [63:0] maj);
    entry_t e;
    e = base;
    e[majIDOffset +: instructionCounterWidth] = maj;
    return e;
  endfunction

  function automatic vec_t mkVec(input logic r, input logic e, input logic rd,
                                 input logic [63:0] maj, input logic v,
                                 input logic s, input logic o, input logic [63:0] em);
    vec_t x;
    x.rst = r; x.en = e; x.rdy = rd; x.maj = maj;
    x.expValid = v; x.expStall = s; x.expOvf = o; x.expMaj = em;
    return x;
  endfunction

  task automatic modelStep(input logic r, input logic f, input logic e,
                           input logic rd, input entry_t d);
    bit p;
    bit acc;
    if (r) begin
      mq.delete();
      mOvf = 1'b0;
    end else if (f) begin
      mq.delete();
    end else begin
      p   = (mq.size() != 0) && rd;
      acc = e && ((mq.size() < depth) || p);
      if (p) void'(mq.pop_front());
      if (acc) mq.push_back(d);
      if (e && !acc) mOvf = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, then compare.
  task automatic cycle(input logic r, input logic f, input logic e,
                       input logic rd, input entry_t d, input string tag);
    entry_t expHead;
    logic   expValid;
    rst = r;
    dif.flush_i  = f;
    dif.enable_i = e;
    dif.ready_i  = rd;
    driveEntry(d);
    @(posedge clk);
    modelStep(r, f, e, rd, d);
    #1;
    expValid = (mq.size() != 0);
    expHead  = expValid ? mq[0] : '0;
    check({tag, ".valid"},    entry_t'(dif.valid_o),    entry_t'(expValid));
    check({tag, ".stall"},    entry_t'(dif.stall_o),    entry_t'(mq.size() >= depth - stallSlack));
    check({tag, ".overflow"}, entry_t'(dif.overflow_o), entry_t'(mOvf));
    check({tag, ".head"},     actualHead(),             expHead);
  endtask

  entry_t base;
  entry_t fmul;
  localparam logic [bodyWidth-1:0] fmulBody = 84'h1171F0000000000000000;

  initial begin
    dif.flush_i  = 1'b0;
    dif.enable_i = 1'b0;
    dif.ready_i  = 1'b0;
    driveEntry('0);

    base = '0;
    base[opcodeOffset +: opcodeSize]           = 12'h01F;
    base[funcUnitTypeOffset +: funcUnitCodeSize] = 3'(fuFX);
    base[pidOffset +: PidSize]                 = 20'hABCDE;
    base[bodyOffset +: bodyWidth]              = 84'h123456789ABCDEF012345;

    // Table: reset, fill to full, drop a 9th, drain, reset again.
    tbl.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0));
    for (int unsigned k = 0; k < 8; k++)
      tbl.push_back(mkVec(0, 1, 0, 64'(k), 1, (k + 1) >= 6, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 8, 1, 1, 1, 0));
    for (int unsigned i = 0; i < 8; i++)
      tbl.push_back(mkVec(0, 0, 1, 0, (7 - i) != 0, (7 - i) >= 6, 1,
                          ((7 - i) != 0) ? 64'(i + 1) : 64'd0));
    tbl.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0));

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle(tbl[i].rst, 1'b0, tbl[i].en, tbl[i].rdy, withMaj(base, tbl[i].maj), t);
      check({t, ".tblValid"}, entry_t'(dif.valid_o),    entry_t'(tbl[i].expValid));
      check({t, ".tblStall"}, entry_t'(dif.stall_o),    entry_t'(tbl[i].expStall));
      check({t, ".tblOvf"},   entry_t'(dif.overflow_o), entry_t'(tbl[i].expOvf));
      check({t, ".tblMaj"},   entry_t'(dif.majID_o),    entry_t'(tbl[i].expMaj));
    end

    // fmul push, hold, then pop.
    fmul = '0;
    fmul[opcodeOffset +: opcodeSize]             = 12'd4;
    fmul[funcUnitTypeOffset +: funcUnitCodeSize] = 3'(fuFP);
    fmul[is64BitOffset]                          = 1'b1;
    fmul[op1rwOffset +: regAccessPatternSize]    = regWrite;
    fmul[op1IsRegOffset]                         = 1'b1;
    fmul[bodyOffset +: bodyWidth]                = fmulBody;
    fmul[majIDOffset +: instructionCounterWidth] = 64'd42;
    cycle(0, 0, 1, 0, fmul, "fmulPush");
    cycle(0, 0, 0, 0, base, "fmulHold");
    check("fmul.opcode", entry_t'(dif.opcode_o),       entry_t'(12'd4));
    check("fmul.fu",     entry_t'(dif.funcUnitType_o), entry_t'(3'd1));
    check("fmul.is64",   entry_t'(dif.is64Bit_o),      entry_t'(1'b1));
    check("fmul.op1rw",  entry_t'(dif.op1rw_o),        entry_t'(2'b01));
    check("fmul.body",   entry_t'(dif.body_o),         entry_t'(fmulBody));
    cycle(0, 0, 0, 1, base, "fmulPop");
    check("fmulPop.valid",  entry_t'(dif.valid_o),  entry_t'(1'b0));
    check("fmulPop.opcode", entry_t'(dif.opcode_o), entry_t'(12'd0));

    // Full queue, simultaneous push and pop, then in-order drain.
    cycle(1, 0, 0, 0, base, "fullRst");
    for (int unsigned k = 0; k < 8; k++)
      cycle(0, 0, 1, 0, withMaj(base, 64'(100 + k)), "fullFill");
    cycle(0, 0, 1, 1, withMaj(base, 64'd108), "fullPushPop");
    check("fullPushPop.ovf",   entry_t'(dif.overflow_o), entry_t'(1'b0));
    check("fullPushPop.stall", entry_t'(dif.stall_o),    entry_t'(1'b1));
    for (int unsigned i = 0; i < 8; i++) begin
      check($sformatf("fullDrain%0d.maj", i), entry_t'(dif.majID_o), entry_t'(64'(101 + i)));
      cycle(0, 0, 0, 1, base, "fullDrain");
    end
    check("fullDrained.valid", entry_t'(dif.valid_o), entry_t'(1'b0));

    // Flush with a same-cycle push: nothing survives.
    cycle(1, 0, 0, 0, base, "flushRst");
    for (int unsigned k = 0; k < 5; k++)
      cycle(0, 0, 1, 0, withMaj(base, 64'(300 + k)), "flushFill");
    cycle(0, 1, 1, 1, withMaj(base, 64'd399), "flushPush");
    check("flush.valid", entry_t'(dif.valid_o), entry_t'(1'b0));
    cycle(0, 0, 0, 1, base, "flushAfter");
    check("flushAfter.valid", entry_t'(dif.valid_o), entry_t'(1'b0));

    // Overflow survives a flush.
    for (int unsigned k = 0; k < 9; k++)
      cycle(0, 0, 1, 0, withMaj(base, 64'(500 + k)), "ovfFill");
    cycle(0, 1, 0, 0, base, "ovfFlush");
    check("ovfFlush.ovf", entry_t'(dif.overflow_o), entry_t'(1'b1));

    // Streaming: one push and one pop per cycle, pointers wrap.
    cycle(1, 0, 0, 0, base, "streamRst");
    for (int unsigned i = 0; i < 20; i++) begin
      cycle(0, 0, 1, 1, withMaj(base, 64'(200 + i)), "stream");
      check($sformatf("stream%0d.maj", i), entry_t'(dif.majID_o), entry_t'(64'(200 + i)));
    end

    // Randomised traffic against the reference model.
    cycle(1, 0, 0, 0, base, "rndRst");
    for (int unsigned i = 0; i < 600; i++) begin
      logic r, f, e, rd;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 3) != 0);
      rd = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      cycle(r, f, e, rd, randEntry(), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
